// File: rtl/ip4_rtl_spa_wb.sv
// SPA writeback queue: buffers execute results and drains them to the VRF,
// returning scoreboard releases and stalling issue before the queue overflows.
module ip4_rtl_spa_wb #(
  parameter int NUM_SP = 8,
  parameter int DATA_W = 32,
  parameter int WID_W  = 3,
  parameter int RID_W  = 8,
  parameter int DEPTH  = 8,
  parameter int SKID   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     res_vld,
  input  logic [WID_W-1:0]         res_wid,
  input  logic [RID_W-1:0]         res_rd,
  input  logic [NUM_SP-1:0]        res_mask,
  input  logic [NUM_SP*DATA_W-1:0] res_data,
  input  logic                     flush_vld,
  input  logic [WID_W-1:0]         flush_wid,
  output logic                     wb_vld,
  input  logic                     wb_rdy,
  output logic [WID_W-1:0]         wb_wid,
  output logic [RID_W-1:0]         wb_rd,
  output logic [NUM_SP-1:0]        wb_mask,
  output logic [NUM_SP*DATA_W-1:0] wb_data,
  output logic                     rel_vld,
  output logic [WID_W-1:0]         rel_wid,
  output logic [RID_W-1:0]         rel_rd,
  output logic                     stall,
  output logic                     ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] THR  = CW'(DEPTH - SKID);

  logic                     kill_q [DEPTH];
  logic [WID_W-1:0]         wid_q  [DEPTH];
  logic [RID_W-1:0]         rd_q   [DEPTH];
  logic [NUM_SP-1:0]        mask_q [DEPTH];
  logic [NUM_SP*DATA_W-1:0] data_q [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          hv, h_kill, h_null, h_write;
  logic          pop, push, ovf, rel_nxt;

  assign hv      = count != '0;
  assign h_kill  = kill_q[rd_ptr];
  assign h_null  = ~h_kill & (mask_q[rd_ptr] == '0);
  assign h_write = hv & ~h_kill & ~h_null;

  assign wb_vld  = h_write;
  assign wb_wid  = wid_q[rd_ptr];
  assign wb_rd   = rd_q[rd_ptr];
  assign wb_mask = mask_q[rd_ptr];
  assign wb_data = data_q[rd_ptr];

  // Null and killed heads retire on their own; writes wait for the VRF.
  assign pop     = hv & (~h_write | wb_rdy);
  assign push    = res_vld & ((count != FULL) | pop);
  assign ovf     = res_vld & ~push;
  assign rel_nxt = pop & ~h_kill;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      rel_vld <= 1'b0;
      rel_wid <= '0;
      rel_rd  <= '0;
      stall   <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      count   <= count_nxt;
      rel_vld <= rel_nxt;
      stall   <= count_nxt >= THR;
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (rel_nxt) begin
        rel_wid <= wid_q[rd_ptr];
        rel_rd  <= rd_q[rd_ptr];
      end
      if (ovf)
        ovf_err <= 1'b1;
    end
  end

  // Incoming entry's own kill bit wins over the sweep for its slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (flush_vld && wid_q[i] == flush_wid)
        kill_q[i] <= 1'b1;
    if (push) begin
      kill_q[wr_ptr] <= flush_vld && (res_wid == flush_wid);
      wid_q[wr_ptr]  <= res_wid;
      rd_q[wr_ptr]   <= res_rd;
      mask_q[wr_ptr] <= res_mask;
      data_q[wr_ptr] <= res_data;
    end
  end

endmodule

// File: doc/ip4_rtl_spa_wb.md
Name: ip4_rtl_spa_wb

Overview:
- Writeback queue directly downstream of the stream processor array (SPA).
- Captures per-instruction vector results leaving the SPA execute pipeline and buffers them in a small FIFO.
- Drains them to the vector register file (VRF) write port under a valid/ready handshake.
- Returns scoreboard-release notifications to the issue engine (ISE), and raises an issue stall early enough to keep the non-stallable SPA pipeline from overflowing the queue.

Parameters:
- NUM_SP, 8: lanes per result; width of the mask.
- DATA_W, 32: bits per lane result.
- WID_W, 3: warp/thread-group id width.
- RID_W, 8: destination register id width.
- DEPTH, 8: FIFO entries; power of two, at least 4.
- SKID, 3: SPA pipeline stages between an ISE issue and its result arriving here; sets the stall threshold.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset.
- res_vld, in, 1: SPA result valid. No backpressure exists on this input.
- res_wid, in, WID_W: warp id of the result.
- res_rd, in, RID_W: destination register.
- res_mask, in, NUM_SP: lane write-enable mask.
- res_data, in, NUM_SP*DATA_W: lane data, lane i at bits [i*DATA_W +: DATA_W].
- flush_vld, in, 1: ISE flush request.
- flush_wid, in, WID_W: warp to flush.
- wb_vld, out, 1: VRF write request.
- wb_rdy, in, 1: VRF accepts the write.
- wb_wid, out, WID_W: warp id of the write.
- wb_rd, out, RID_W: destination register of the write.
- wb_mask, out, NUM_SP: lane write-enable mask of the write.
- wb_data, out, NUM_SP*DATA_W: lane data of the write.
- rel_vld, out, 1: scoreboard release pulse.
- rel_wid, out, WID_W: warp id being released.
- rel_rd, out, RID_W: register being released.
- stall, out, 1: ISE must not issue SPA instructions.
- ovf_err, out, 1: sticky overflow error.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n low at a rising edge), including mid-operation:
  - count, rd_ptr, wr_ptr := 0. All queued entries are discarded.
  - rel_vld, ovf_err := 0.
  - Storage contents are don't-care.
  - With count 0, wb_vld and stall are 0 in the cycle after reset.
- Storage and entry format:
  - Circular FIFO of DEPTH entries, each {kill, wid, rd, mask, data}.
  - count ranges 0..DEPTH. Pointers wrap modulo DEPTH.
- Head outputs:
  - wb_wid, wb_rd, wb_mask and wb_data are driven from the head entry's registers, with no combinational path from res_*.
  - Latency: a result pushed at edge N is visible on wb_* in cycle N+1 at the earliest.
- Head classification when count>0:
  - WRITE: kill==0 and mask!=0. Drives wb_vld=1. Pops on wb_vld & wb_rdy.
  - NULL: kill==0 and mask==0. wb_vld=0. Auto-pops in 1 cycle and produces a release.
  - KILLED: kill==1. wb_vld=0. Auto-pops in 1 cycle with no release.
- wb_vld stays 0 whenever count==0. Once asserted, wb_vld and wb_* hold stable until the handshake completes, unless the head is killed by a flush in that cycle; wb_vld then drops at the next edge.
- Release:
  - Registered: rel_vld pulses 1 cycle after a WRITE handshake or a NULL pop.
  - rel_wid and rel_rd carry the popped entry's fields.
  - At most one release per cycle, since there is at most one pop per cycle.
- Push: res_vld pushes {0, res_wid, res_rd, res_mask, res_data} at wr_ptr.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, a pop in the same cycle frees the slot, so the push is accepted.
- Overflow:
  - Condition: res_vld while count==DEPTH and no pop this cycle.
  - The result is dropped, ovf_err is set and stays set until reset, and the queue state is otherwise unchanged.
- Stall: registered, stall := (next count >= DEPTH-SKID). This guarantees that SKID in-flight results fit in the queue.
- Flush: flush_vld sets kill=1 on every stored entry whose wid==flush_wid, including the head.
  - A same-cycle push whose res_wid==flush_wid is stored with kill=1.
  - If the head is WRITE and is handshaking in the flush cycle, the write completes and its release is still issued. Flush affects only entries not yet popped.
- Arithmetic: count uses $clog2(DEPTH)+1 bits and pointers use $clog2(DEPTH) bits. No saturation is needed because the overflow rule blocks count>DEPTH.

Test Plan:
1. Single result: res_vld at cycle 0 with wid=2, rd=0x15, mask=0xFF, wb_rdy=1. Required: wb_vld=1 in cycle 1 with matching fields; rel_vld=1, rel_wid=2, rel_rd=0x15 in cycle 2; count returns to 0.
2. Backpressure and stall: wb_rdy=0 with 6 back-to-back results. Required: stall rises after the 5th push (count=5 >= 8-3); count=6, no ovf_err. Then raise wb_rdy. Required: 6 writes in push order, stall drops when count falls below 5.
3. Full plus push/pop: fill to 8 with wb_rdy=0, then res_vld=1 with wb_rdy=1 in the same cycle. Required: count stays 8, ovf_err=0. Next cycle res_vld=1 with wb_rdy=0. Required: ovf_err=1 and the result is dropped.
4. Null mask: push mask=0x00 for rd=0x07. Required: wb_vld never asserts for that entry; rel_vld pulses with rel_rd=0x07 two cycles after the push.
5. Flush: queue holds wid {1,3,1,2} and flush_wid=1 arrives while the head (wid 1) is stalled with wb_rdy=0. Required: only the wid 3 and wid 2 entries are written and released; wid 1 entries produce neither wb_vld nor rel_vld.
6. Reset mid-run: rst_n=0 for 1 cycle with count=4 and ovf_err=1. Required: next cycle count=0, wb_vld=0, stall=0, rel_vld=0, ovf_err=0.
